hazard_controller: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS datapath. Each cycle it decides which pipeline latches (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) load, hold or take a bubble. Its inputs are cache hit/wait status, load-use hazards, taken branches, jumps and halt. It sits beside the forwarding unit: forwarding covers ALU-to-ALU dependencies, and this block covers everything forwarding cannot, including load-use, memory wait, control-flow flush and halt.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/hazard_controller_if.sv | 69 ++++++
 rtl/hazard_perf_counters.sv | 44 ++++
 rtl/hazard_controller.sv | 101 ++++++++++
 tb/tb_hazard_controller.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register-index width and the hazard controller state encoding.
package cpu_types_pkg;

    localparam int unsigned REGBITS = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        IWAIT  = 2'd1,
        DWAIT  = 2'd2,
        HALTED = 2'd3
    } hazard_state_t;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    function automatic logic load_use(input logic               ex_dren,
                                      input logic [REGBITS-1:0] ex_wsel,
                                      input logic [REGBITS-1:0] id_rs,
                                      input logic [REGBITS-1:0] id_rt);
        return ex_dren && (ex_wsel != '0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Signal bundle between the hazard controller and its environment (all but clock and reset).
// Counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_controller_if
`ifdef HAZARD_PERF_EN
    #(parameter int unsigned CNT_W = 32)
`endif
    ;
    import cpu_types_pkg::*;

    logic               ihit;
    logic               dhit;
    logic               mem_dren;
    logic               mem_dwen;
    logic               ex_dren;
    logic [REGBITS-1:0] ex_wsel;
    logic [REGBITS-1:0] id_rs;
    logic [REGBITS-1:0] id_rt;
    logic               mem_branch_taken;
    logic               id_jump;
    logic               wb_halt;

    logic               pc_en;
    logic               if_id_en;
    logic               id_ex_en;
    logic               ex_mem_en;
    logic               mem_wb_en;
    logic               if_id_flush;
    logic               id_ex_flush;
    logic               ex_mem_flush;
    logic               halt;
    hazard_state_t      state;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]   luse_cnt;

    modport hc (
        input  ihit, dhit, mem_dren, mem_dwen, ex_dren, ex_wsel, id_rs, id_rt,
               mem_branch_taken, id_jump, wb_halt,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, halt, state,
               stall_cnt, flush_cnt, luse_cnt
    );

    modport tb (
        output ihit, dhit, mem_dren, mem_dwen, ex_dren, ex_wsel, id_rs, id_rt,
               mem_branch_taken, id_jump, wb_halt,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, halt, state,
               stall_cnt, flush_cnt, luse_cnt
    );
`else
    modport hc (
        input  ihit, dhit, mem_dren, mem_dwen, ex_dren, ex_wsel, id_rs, id_rt,
               mem_branch_taken, id_jump, wb_halt,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, halt, state
    );

    modport tb (
        output ihit, dhit, mem_dren, mem_dwen, ex_dren, ex_wsel, id_rs, id_rt,
               mem_branch_taken, id_jump, wb_halt,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, halt, state
    );
`endif

endinterface

// File: rtl/hazard_perf_counters.sv
// Three saturating event counters (stall, flush, load-use) for the hazard controller.
module hazard_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    input  logic             luse_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] luse_cnt_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] luse_q,  luse_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        luse_d  = luse_q;
        if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (flush_inc_i && (flush_q != '1)) flush_d = flush_q + 1'b1;
        if (luse_inc_i  && (luse_q  != '1)) luse_d  = luse_q  + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
            luse_q  <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
            luse_q  <= luse_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
    assign luse_cnt_o  = luse_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline latch sequencing for the five-stage datapath: stall, bubble, flush and halt.
// Performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_controller
`ifdef HAZARD_PERF_EN
    #(parameter int unsigned CNT_W = 32)
`endif
(
    input logic             CLK,
    input logic             RST,
    hazard_controller_if.hc hif
);
    import cpu_types_pkg::*;

    hazard_state_t state_q, state_d;
    logic          halt_q;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush;
    logic          luse_cycle;
    logic          dwait;

    assign dwait = (hif.mem_dren | hif.mem_dwen) & ~hif.dhit;

    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        luse_cycle   = 1'b0;
        if (RST) begin
            state_d = RUN;
        end else if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (hif.wb_halt) begin
            state_d = HALTED;
        end else if (dwait) begin
            // Whole pipe frozen; a pending branch flush waits for the dhit cycle.
            state_d = DWAIT;
        end else if (hif.mem_branch_taken) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            {if_id_flush, id_ex_flush, ex_mem_flush}          = '1;
            state_d = RUN;
        end else if (load_use(hif.ex_dren, hif.ex_wsel, hif.id_rs, hif.id_rt)) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            luse_cycle  = 1'b1;
            state_d     = hif.ihit ? RUN : IWAIT;
        end else if (!hif.ihit) begin
            {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            if_id_flush = 1'b1;
            state_d     = IWAIT;
        end else begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            if_id_flush = hif.id_jump;
            state_d     = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == HALTED);
        end
    end

    assign hif.pc_en        = pc_en;
    assign hif.if_id_en     = if_id_en;
    assign hif.id_ex_en     = id_ex_en;
    assign hif.ex_mem_en    = ex_mem_en;
    assign hif.mem_wb_en    = mem_wb_en;
    assign hif.if_id_flush  = if_id_flush;
    assign hif.id_ex_flush  = id_ex_flush;
    assign hif.ex_mem_flush = ex_mem_flush;
    assign hif.halt         = halt_q;
    assign hif.state        = state_q;

`ifdef HAZARD_PERF_EN
    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk_i       (CLK),
        .rst_i       (RST),
        .stall_inc_i (!RST && (state_q != HALTED) && !pc_en),
        .flush_inc_i (if_id_flush | id_ex_flush | ex_mem_flush),
        .luse_inc_i  (luse_cycle),
        .stall_cnt_o (hif.stall_cnt),
        .flush_cnt_o (hif.flush_cnt),
        .luse_cnt_o  (hif.luse_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller; counter checks only under HAZARD_PERF_EN.
module tb_hazard_controller;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    hazard_controller_if hif ();

    hazard_controller dut (
        .CLK (clk),
        .RST (rst),
        .hif (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] en_v;
    logic [2:0] fl_v;
    assign en_v = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en};
    assign fl_v = {hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [4:0] en, input logic [2:0] fl);
        check_eq({tag, "_en"}, 32'(en_v), 32'(en));
        check_eq({tag, "_flush"}, 32'(fl_v), 32'(fl));
    endtask

    task automatic check_st(input string tag, input logic [1:0] st, input logic hl);
        check_eq({tag, "_state"}, 32'(hif.state), 32'(st));
        check_eq({tag, "_halt"}, 32'(hif.halt), 32'(hl));
    endtask

    task automatic check_cnt(input string tag, input int s, input int f, input int l);
`ifdef HAZARD_PERF_EN
        check_eq({tag, "_stall_cnt"}, 32'(hif.stall_cnt), 32'(s));
        check_eq({tag, "_flush_cnt"}, 32'(hif.flush_cnt), 32'(f));
        check_eq({tag, "_luse_cnt"}, 32'(hif.luse_cnt), 32'(l));
`else
        if (s < 0 || f < 0 || l < 0) $display("bad counter expectation in %s", tag);
`endif
    endtask

    task automatic idle();
        hif.ihit = 1'b1; hif.dhit = 1'b0; hif.mem_dren = 1'b0; hif.mem_dwen = 1'b0;
        hif.ex_dren = 1'b0; hif.ex_wsel = '0; hif.id_rs = '0; hif.id_rt = '0;
        hif.mem_branch_taken = 1'b0; hif.id_jump = 1'b0; hif.wb_halt = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst = 1'b1;
        sample(); check_ctrl("in_reset", 5'b00000, 3'b000);
        next(); rst = 1'b0;
        sample(); check_st("after_reset", 2'd0, 1'b0); check_ctrl("run_idle", 5'b11111, 3'b000);
        check_cnt("after_reset", 0, 0, 0);

        // load-use bubble, then release
        next(); hif.ex_dren = 1'b1; hif.ex_wsel = 5'd8; hif.id_rs = 5'd8;
        sample(); check_ctrl("luse", 5'b00111, 3'b010);
        next(); idle();
        sample(); check_ctrl("luse_release", 5'b11111, 3'b000); check_st("luse_release", 2'd0, 1'b0);
        check_cnt("luse_release", 1, 1, 1);

        // r0 destination never stalls
        next(); hif.ex_dren = 1'b1; hif.ex_wsel = 5'd0; hif.id_rt = 5'd0;
        sample(); check_ctrl("luse_r0", 5'b11111, 3'b000);

        // load-use with i-miss goes to IWAIT
        next(); idle(); hif.ex_dren = 1'b1; hif.ex_wsel = 5'd8; hif.id_rt = 5'd8; hif.ihit = 1'b0;
        sample(); check_ctrl("luse_imiss", 5'b00111, 3'b010);
        next(); idle();
        sample(); check_st("luse_imiss_next", 2'd1, 1'b0); check_ctrl("iwait_hit", 5'b11111, 3'b000);

        // data wait three cycles, then dhit
        next(); do_reset();
        hif.mem_dren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample(); check_ctrl("dwait", 5'b00000, 3'b000);
            if (i > 0) check_st("dwait", 2'd2, 1'b0);
            next();
        end
        hif.dhit = 1'b1;
        sample(); check_ctrl("dwait_dhit", 5'b11111, 3'b000); check_st("dwait_dhit", 2'd2, 1'b0);
        next(); idle();
        sample(); check_st("dwait_done", 2'd0, 1'b0); check_cnt("dwait_done", 3, 0, 0);

        // branch held behind a data wait
        next(); hif.mem_dren = 1'b1; hif.mem_branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample(); check_ctrl("br_wait", 5'b00000, 3'b000);
            next();
        end
        hif.dhit = 1'b1;
        sample(); check_ctrl("br_dhit", 5'b11111, 3'b111);
        next(); idle();
        sample(); check_st("br_done", 2'd0, 1'b0); check_cnt("br_done", 5, 1, 0);

        // taken branch overrides i-miss
        next(); hif.mem_branch_taken = 1'b1; hif.ihit = 1'b0;
        sample(); check_ctrl("br_imiss", 5'b11111, 3'b111);

        // i-miss with jump, then fetch completes
        next(); idle(); hif.ihit = 1'b0; hif.id_jump = 1'b1;
        sample(); check_ctrl("jmp_imiss", 5'b01111, 3'b100);
        next(); hif.ihit = 1'b1;
        sample(); check_st("jmp_iwait", 2'd1, 1'b0); check_ctrl("jmp_hit", 5'b11111, 3'b100);
        next(); idle();
        sample(); check_st("jmp_done", 2'd0, 1'b0);

        // dhit arrives while fetch still missing
        next(); hif.mem_dren = 1'b1; hif.dhit = 1'b1; hif.ihit = 1'b0;
        sample(); check_ctrl("dhit_imiss", 5'b01111, 3'b100);

        // reset in the middle of a data wait
        next(); idle(); hif.mem_dren = 1'b1;
        next();
        sample(); check_st("pre_rst_dwait", 2'd2, 1'b0);
        next(); rst = 1'b1;
        sample(); check_ctrl("rst_dwait", 5'b00000, 3'b000);
        next(); rst = 1'b0; idle();
        sample(); check_st("rst_dwait_out", 2'd0, 1'b0); check_ctrl("rst_dwait_out", 5'b11111, 3'b000);
        check_cnt("rst_dwait_out", 0, 0, 0);

        // halt beats a simultaneous data wait, then holds regardless of inputs
        next(); hif.wb_halt = 1'b1; hif.mem_dren = 1'b1;
        sample(); check_ctrl("halt_req", 5'b00000, 3'b000); check_st("halt_req", 2'd0, 1'b0);
        next();
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i % 2 == 1) begin
                hif.mem_branch_taken = 1'b1; hif.ihit = 1'b0;
            end else begin
                hif.id_jump = 1'b1; hif.ex_dren = 1'b1; hif.ex_wsel = 5'd3; hif.id_rs = 5'd3;
            end
            sample(); check_ctrl("halted", 5'b00000, 3'b000); check_st("halted", 2'd3, 1'b1);
            next();
        end
        check_cnt("halted", 1, 0, 0);
        rst = 1'b1;
        next(); rst = 1'b0; idle();
        sample(); check_st("halt_rst", 2'd0, 1'b0); check_ctrl("halt_rst", 5'b11111, 3'b000);
        check_cnt("halt_rst", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
